seq_restoring_divider: RTL and testbench
========================================

Name: seq_restoring_divider

Overview:
- Iterative unsigned restoring divider. It is the subtract-direction counterpart to the team's combinational carry-lookahead adder.
- Each iteration is one shift-and-trial-subtract step. A subtract is an add of the two's complement with carry-in 1, so the adder datapath style is reused.
- It sits beside the ALU as a multi-cycle functional unit.
- Uses a start/busy/done handshake and delivers quotient and remainder after a fixed number of cycles.

Parameters:
- N, 8, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request a division; sampled only when busy=0.
- dividend  input  N  unsigned dividend, captured when start is accepted.
- divisor  input  N  unsigned divisor, captured when start is accepted.
- busy  output  1  high while iterations are in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- quotient  output  N  unsigned quotient, held until the next accepted start.
- remainder  output  N  unsigned remainder, held until the next accepted start.

Behaviour:
- Reset: rst_n=0 at a rising edge forces:
  - state=IDLE, busy=0, done=0, quotient=0, remainder=0, iteration count=0.
  - Reset applies in any state, including mid-RUN. A partial result is discarded and never reported.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge loads rem=0, quo=dividend, dvs=divisor, count=N, and moves to RUN.
  - RUN: one iteration per edge.
    - {rem,quo} shifts left 1.
    - trial = {1'b0,rem_shifted} - {1'b0,dvs}, computed at N+1 bits.
    - If trial[N]=0: rem=trial[N-1:0] and quo[0]=1. Otherwise rem is unchanged (restore) and quo[0]=0.
    - count decrements. When count reaches 1, the state moves to DONE after that edge's iteration.
  - DONE: done=1 for exactly one cycle.
    - quotient and remainder registers show the final values.
    - The next edge returns to IDLE, or loads and enters RUN if start=1.
- Latency:
  - start high in cycle 0 is accepted at the end of cycle 0.
  - busy is high in cycles 1..N.
  - done is high in cycle N+1.
  - Fixed, data-independent, except the divide-by-zero case under the optional feature.
- Handshake:
  - start while busy=1 is ignored and has no side effects; operands are not re-captured.
  - start during the DONE cycle is accepted, giving back-to-back operations with no idle cycle.
  - start held high continuously restarts after every DONE.
- Outputs:
  - quotient/remainder change only on the edge entering DONE, or on reset.
  - During RUN they hold the previous result; internal working registers are separate.
  - done and busy are never high together.
- Arithmetic: the trial subtract uses N+1 bits so divisors with the MSB set compare correctly. No overflow is possible for unsigned operands.
- Divisor=0 (base behaviour): the algorithm runs naturally and yields quotient = all ones (2^N-1) and remainder = dividend.
- Dividend < divisor yields quotient=0, remainder=dividend.

Optional Feature:
- Macro: DIV_BY_ZERO_ERR_EN.
- Defined:
  - Adds output port div_err (1 bit), reset value 0.
  - If divisor=0 at accept, the block skips RUN and goes IDLE->DONE. done is high in cycle 2 (two cycles after start is accepted).
  - quotient=2^N-1, remainder=dividend, div_err=1.
  - div_err is cleared on the next accepted start and on reset.
- Not defined: no div_err port. Divisor=0 takes the full N iterations with the same quotient/remainder values.

Test Plan:
- N=8, reset then dividend=100, divisor=7, start pulse in cycle 0 -> busy in cycles 1..8; done only in cycle 9; quotient=14, remainder=2; both held afterwards.
- Boundary operands:
  - 255/1 -> Q=255, R=0.
  - 5/200 -> Q=0, R=5.
  - 0/13 -> Q=0, R=0.
  - 200/200 -> Q=1, R=0.
  - 255/128 -> Q=1, R=127.
- start re-pulsed with 50/3 at cycle 4 of a 100/7 run -> ignored; done at cycle 9 with Q=14, R=2.
- Back-to-back:
  - 100/7 started; start held high with 50/3 during the done cycle -> second done exactly 9 cycles later, Q=16, R=2.
  - No extra idle cycle; first result visible until the second done.
- rst_n=0 in cycle 5 of a run -> next cycle busy=0, done=0, Q=0, R=0; no done pulse follows.
- 77/0:
  - Without DIV_BY_ZERO_ERR_EN: done in cycle 9, Q=255, R=77.
  - With it: done in cycle 2, Q=255, R=77, div_err=1. A following 10/2 gives div_err=0, Q=5, R=0.

Source files
------------

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned restoring divider (N-bit).
// Each RUN cycle performs one shift-and-trial-subtract step. The subtract is
// an add of the two's complement with carry-in 1, matching the adder style.
// Optional feature macro: DIV_BY_ZERO_ERR_EN. It adds a div_err output, and a
// zero divisor then short-cuts to DONE instead of running N iterations.
module seq_restoring_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
`ifdef DIV_BY_ZERO_ERR_EN
   ,output logic         div_err
`endif
);

    localparam int CW = $clog2(N + 1);

    // ZERO is the single wait cycle of the divide-by-zero short-cut.
    typedef enum logic [1:0] {IDLE, RUN, DONE, ZERO} state_t;

    state_t         state, state_nxt;
    logic           accept;
    logic [CW-1:0]  count;
    logic [N-1:0]   rem_w, quo_w, dvs;
    logic [N:0]     rem_sh, trial;
    logic [N-1:0]   rem_nxt, quo_nxt;

    // Next state, handshake outputs and the single iteration step.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        // The shifted partial remainder keeps its carry-out bit. Since
        // rem < dvs, rem_sh - dvs lies in (-2^N, 2^N), so bit N of the
        // N+1-bit difference is a reliable borrow flag.
        rem_sh    = {rem_w, quo_w[N-1]};
        trial     = rem_sh + ~{1'b0, dvs} + (N+1)'(1);
        rem_nxt   = trial[N] ? rem_sh[N-1:0] : trial[N-1:0];
        quo_nxt   = {quo_w[N-2:0], ~trial[N]};
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
`ifdef DIV_BY_ZERO_ERR_EN
                    if (divisor == '0) state_nxt = ZERO;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == CW'(1)) state_nxt = DONE;
            end
`ifdef DIV_BY_ZERO_ERR_EN
            ZERO: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Working registers, iteration counter and held result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_w     <= '0;
            quo_w     <= '0;
            dvs       <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_BY_ZERO_ERR_EN
            div_err   <= 1'b0;
`endif
        end else if (accept) begin
            rem_w   <= '0;
            quo_w   <= dividend;
            dvs     <= divisor;
            count   <= CW'(N);
`ifdef DIV_BY_ZERO_ERR_EN
            div_err <= 1'b0;
`endif
        end else if (state == RUN) begin
            rem_w <= rem_nxt;
            quo_w <= quo_nxt;
            count <= count - CW'(1);
            // Results become visible only on the edge that enters DONE.
            if (count == CW'(1)) begin
                quotient  <= quo_nxt;
                remainder <= rem_nxt;
            end
        end
`ifdef DIV_BY_ZERO_ERR_EN
        else if (state == ZERO) begin
            quotient  <= '1;
            remainder <= quo_w;
            div_err   <= 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: a cycle-level behavioural
// model built from plain division plus a latency countdown, a per-cycle
// compare process, and literal expectations for directed operand sets.
module tb_seq_restoring_divider;
    localparam int N = 8;
`ifdef DIV_BY_ZERO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0, divisor = '0;
    logic         busy, done;
    logic [N-1:0] quotient, remainder;
`ifdef DIV_BY_ZERO_ERR_EN
    logic         div_err;
`endif

    seq_restoring_divider #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder)
`ifdef DIV_BY_ZERO_ERR_EN
       ,.div_err(div_err)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? (1 << N) - 1 : a / b;
    endfunction
    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    // Behavioural model: an accepted operation finishes `left` cycles later.
    int left = 0;
    bit m_done = 1'b0, m_err = 1'b0, p_err = 1'b0;
    int m_q = 0, m_r = 0, p_q = 0, p_r = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            left = 0; m_done = 0; m_q = 0; m_r = 0; m_err = 0;
        end else begin
            m_done = 0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    m_done = 1; m_q = p_q; m_r = p_r; m_err = p_err;
                end
            end else if (start) begin
                p_q   = ref_q(int'(dividend), int'(divisor));
                p_r   = ref_r(int'(dividend), int'(divisor));
                p_err = ERR_EN && (divisor == '0);
                left  = p_err ? 1 : N;
                m_err = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, (left > 0));
            chk("done", done, m_done);
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("busy_done_excl", busy & done, 0);
`ifdef DIV_BY_ZERO_ERR_EN
            chk("div_err", div_err, m_err);
`endif
        end
    end

    // Issue one start (called at a negedge), optionally pulse a junk start
    // while busy, and return at the negedge of the done cycle.
    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input int junk_at,
                      input logic [N-1:0] ja, input logic [N-1:0] jb, output int lat);
        start = 1'b1; dividend = a; divisor = b; lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done) begin lat = k; break; end
            start = (k == junk_at); dividend = ja; divisor = jb;
        end
        start = 1'b0;
    endtask

    int lat;
    int ta[5] = '{255, 5, 0, 200, 255};
    int tb[5] = '{1, 200, 13, 200, 128};
    int tq[5] = '{255, 0, 0, 1, 1};
    int tr[5] = '{0, 5, 0, 0, 127};

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_q", quotient, 0); chk("rst_r", remainder, 0);
        rst_n = 1'b1;
        @(negedge clk);

        op(8'd100, 8'd7, 0, 8'd0, 8'd0, lat);
        chk("lat_100_7", lat, 9); chk("q_100_7", quotient, 14); chk("r_100_7", remainder, 2);
        repeat (3) @(negedge clk);
        chk("hold_q", quotient, 14); chk("hold_r", remainder, 2);

        for (int i = 0; i < 5; i++) begin
            op(N'(ta[i]), N'(tb[i]), 0, 8'd0, 8'd0, lat);
            chk("lat_bnd", lat, 9); chk("q_bnd", quotient, tq[i]); chk("r_bnd", remainder, tr[i]);
            @(negedge clk);
        end

        // Start re-pulsed mid-run with different operands must be ignored.
        op(8'd100, 8'd7, 4, 8'd50, 8'd3, lat);
        chk("lat_ign", lat, 9); chk("q_ign", quotient, 14); chk("r_ign", remainder, 2);
        @(negedge clk);

        // Back-to-back: second start issued during the done cycle.
        op(8'd100, 8'd7, 0, 8'd0, 8'd0, lat);
        chk("q_b2b1", quotient, 14);
        op(8'd50, 8'd3, 0, 8'd0, 8'd0, lat);
        chk("lat_b2b2", lat, 9); chk("q_b2b2", quotient, 16); chk("r_b2b2", remainder, 2);

        // Reset in cycle 5 of a run.
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy", busy, 0); chk("mrst_done", done, 0);
        chk("mrst_q", quotient, 0); chk("mrst_r", remainder, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("mrst_no_done", done, 0);
        end

        // Divide by zero, then a normal division clearing the error.
        op(8'd77, 8'd0, 0, 8'd0, 8'd0, lat);
        chk("lat_77_0", lat, ERR_EN ? 2 : 9);
        chk("q_77_0", quotient, 255); chk("r_77_0", remainder, 77);
`ifdef DIV_BY_ZERO_ERR_EN
        chk("err_77_0", div_err, 1);
`endif
        @(negedge clk);
        op(8'd10, 8'd2, 0, 8'd0, 8'd0, lat);
        chk("lat_10_2", lat, 9); chk("q_10_2", quotient, 5); chk("r_10_2", remainder, 0);
`ifdef DIV_BY_ZERO_ERR_EN
        chk("err_10_2", div_err, 0);
`endif
        @(negedge clk);

        // Randomized operations with junk starts and random gaps.
        for (int i = 0; i < 150; i++) begin
            int a, b, sel, junk;
            a   = $urandom_range(0, 255);
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 0;
                1: b = 1;
                2: b = $urandom_range(128, 255);
                3: begin b = a + $urandom_range(0, 20); if (b > 255) b = 255; end
                default: b = $urandom_range(1, 255);
            endcase
            junk = (ERR_EN && b == 0) ? 0 : $urandom_range(0, 8);
            op(N'(a), N'(b), junk, N'($urandom), N'($urandom), lat);
            chk("lat_rnd", lat, (ERR_EN && b == 0) ? 2 : 9);
            chk("q_rnd", quotient, ref_q(a, b));
            chk("r_rnd", remainder, ref_r(a, b));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
